// File: rtl/contador_tempo.sv
// contador_tempo: loadable down-counting timer with a small control FSM.
// S is loaded during a one-cycle LOAD state and then decremented on each
// one-second tick until zero. The binary count, its BCD digits and the
// control permissions are all registered outputs.
module contador_tempo #(
  parameter int unsigned WIDTH       = 5,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic             start,
  input  logic             tick,
  input  logic             pause,
  input  logic             restart,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       tens,
  output logic [3:0]       units,
  output logic             load_permission,
  output logic             clear_permission,
  output logic             count_permission,
  output logic             done,
  output logic [2:0]       state
);

  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] RUN  = 3'b010;
  localparam logic [2:0] HOLD = 3'b011;
  localparam logic [2:0] DONE = 3'b100;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             load_q, load_d;
  logic             clr_q, clr_d;
  logic             cnt_en_q, cnt_en_d;
  logic             done_q, done_d;
  logic [31:0]      count_ext;

  // Next state and next count, with restart overriding every state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (start && (S != '0)) state_d = LOAD;
      end
      LOAD: begin
        count_d = S;
        state_d = RUN;
      end
      RUN: begin
        if (start) begin
          state_d = LOAD;
        end else if (!pause) begin
          state_d = HOLD;
        end else if (tick) begin
          // Count of 0 or 1 both land on zero; never wrap below zero.
          if (count_q <= WIDTH'(1)) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      HOLD: begin
        if (start)      state_d = LOAD;
        else if (pause) state_d = RUN;
      end
      DONE: begin
        count_d = '0;
        if (start || AUTO_RELOAD) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    if (!restart) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  // Registered-output values derived from the next state and next count.
  always_comb begin
    count_ext = 32'(count_d);
    tens_d    = 2'(count_ext / 32'd10);
    units_d   = 4'(count_ext % 32'd10);
    load_d    = (state_d == LOAD);
    clr_d     = (state_d != IDLE);
    cnt_en_d  = (state_d == RUN) && pause;
    done_d    = (state_d == DONE);
  end

  // State, count and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      tens_q   <= '0;
      units_q  <= '0;
      load_q   <= 1'b0;
      clr_q    <= 1'b0;
      cnt_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      load_q   <= load_d;
      clr_q    <= clr_d;
      cnt_en_q <= cnt_en_d;
      done_q   <= done_d;
    end
  end

  assign count            = count_q;
  assign tens             = tens_q;
  assign units            = units_q;
  assign load_permission  = load_q;
  assign clear_permission = clr_q;
  assign count_permission = cnt_en_q;
  assign done             = done_q;
  assign state            = state_q;

endmodule

// File: tb/tb_contador_tempo.sv
// Testbench for contador_tempo: one instance without and one with
// auto-reload, both driven by the same stimulus and compared every cycle
// against a behavioural model of the timer.
module tb_contador_tempo;

  logic       clk = 1'b0;
  logic       rst, start, tick, pause, restart;
  logic [4:0] S;

  logic [4:0] cnt_o   [2];
  logic [1:0] tens_o  [2];
  logic [3:0] units_o [2];
  logic       lp_o    [2];
  logic       cp_o    [2];
  logic       kp_o    [2];
  logic       dn_o    [2];
  logic [2:0] st_o    [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int phase;   // 0 idle, 1 load, 2 run, 3 hold, 4 done
    int remain;
  } mdl_t;

  mdl_t m [2];

  always #5 clk = ~clk;

  contador_tempo #(.WIDTH(5), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .S(S), .start(start), .tick(tick), .pause(pause),
    .restart(restart), .count(cnt_o[0]), .tens(tens_o[0]), .units(units_o[0]),
    .load_permission(lp_o[0]), .clear_permission(cp_o[0]),
    .count_permission(kp_o[0]), .done(dn_o[0]), .state(st_o[0])
  );

  contador_tempo #(.WIDTH(5), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .S(S), .start(start), .tick(tick), .pause(pause),
    .restart(restart), .count(cnt_o[1]), .tens(tens_o[1]), .units(units_o[1]),
    .load_permission(lp_o[1]), .clear_permission(cp_o[1]),
    .count_permission(kp_o[1]), .done(dn_o[1]), .state(st_o[1])
  );

  function automatic mdl_t step(mdl_t cur, bit auto_rl);
    mdl_t n = cur;
    if (rst || !restart) begin
      n.phase  = 0;
      n.remain = 0;
    end else begin
      case (cur.phase)
        0: if (start && S != 0) n.phase = 1;
        1: begin n.remain = int'(S); n.phase = 2; end
        2: begin
          if (start) n.phase = 1;
          else if (!pause) n.phase = 3;
          else if (tick) begin
            n.remain = (cur.remain > 0) ? cur.remain - 1 : 0;
            if (n.remain == 0) n.phase = 4;
          end
        end
        3: if (start) n.phase = 1; else if (pause) n.phase = 2;
        default: begin
          n.remain = 0;
          if (start || auto_rl) n.phase = 1;
        end
      endcase
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int t = 0;
      int r = m[i].remain;
      while (r >= 10) begin r -= 10; t++; end
      chk($sformatf("count%0d", i), 32'(cnt_o[i]), m[i].remain);
      chk($sformatf("tens%0d", i), 32'(tens_o[i]), t);
      chk($sformatf("units%0d", i), 32'(units_o[i]), r);
      chk($sformatf("load_perm%0d", i), 32'(lp_o[i]), 32'(m[i].phase == 1));
      chk($sformatf("clear_perm%0d", i), 32'(cp_o[i]), 32'(m[i].phase != 0));
      chk($sformatf("count_perm%0d", i), 32'(kp_o[i]), 32'(m[i].phase == 2 && pause));
      chk($sformatf("done%0d", i), 32'(dn_o[i]), 32'(m[i].phase == 4));
      chk($sformatf("state%0d", i), 32'(st_o[i]), m[i].phase);
    end
  endtask

  // One clock edge: advance the model with the inputs that were sampled,
  // then compare just after the edge.
  task automatic cyc();
    @(posedge clk);
    m[0] = step(m[0], 1'b0);
    m[1] = step(m[1], 1'b1);
    #1;
    compare_all();
  endtask

  task automatic cycles(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    m[0] = '{phase: 0, remain: 0};
    m[1] = '{phase: 0, remain: 0};
    rst = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b1; restart = 1'b1; S = 5'd0;
    #2;
    cycles(2);
    chk("reset_state", 32'(st_o[0]), 0);
    chk("reset_clear", 32'(cp_o[0]), 0);
    rst = 1'b0;

    // Ticks with no start leave the timer idle at zero.
    tick = 1'b1;
    cycles(3);
    chk("idle_tick_count", 32'(cnt_o[0]), 0);
    tick = 1'b0;

    // Load 6 and count down to done.
    S = 5'd6; start = 1'b1;
    cyc();
    chk("load6_perm", 32'(lp_o[0]), 1);
    start = 1'b0;
    cyc();
    chk("load6_count", 32'(cnt_o[0]), 6);
    chk("load6_units", 32'(units_o[0]), 6);
    tick = 1'b1;
    cycles(6);
    chk("s6_done", 32'(dn_o[0]), 1);
    chk("s6_state", 32'(st_o[0]), 4);
    tick = 1'b0;
    // Auto-reload instance leaves DONE after one cycle, then reloads 6.
    cyc();
    chk("ar_load_state", 32'(st_o[1]), 1);
    chk("ar_done_low", 32'(dn_o[1]), 0);
    cyc();
    chk("ar_count", 32'(cnt_o[1]), 6);
    cycles(3);
    chk("hold_done", 32'(dn_o[0]), 1);
    restart = 1'b0;
    cyc();
    restart = 1'b1;

    // Load 24: BCD, pause, restart mid-count.
    S = 5'd24; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("s24_tens", 32'(tens_o[0]), 2);
    chk("s24_units", 32'(units_o[0]), 4);
    tick = 1'b1;
    cycles(4);
    chk("s24_at20", 32'(cnt_o[0]), 20);
    pause = 1'b0;
    cycles(3);
    chk("pause_count", 32'(cnt_o[0]), 20);
    chk("pause_state", 32'(st_o[0]), 3);
    chk("pause_perm", 32'(kp_o[0]), 0);
    pause = 1'b1;
    cyc();
    cyc();
    chk("resume_count", 32'(cnt_o[0]), 19);
    cycles(7);
    chk("s24_at12", 32'(cnt_o[0]), 12);
    restart = 1'b0;
    cyc();
    chk("restart_count", 32'(cnt_o[0]), 0);
    chk("restart_state", 32'(st_o[0]), 0);
    restart = 1'b1; tick = 1'b0;

    // 15 ticks from 24 reach 9.
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    tick = 1'b1;
    cycles(15);
    chk("s24_at9", 32'(cnt_o[0]), 9);
    chk("s24_tens9", 32'(tens_o[0]), 0);
    chk("s24_units9", 32'(units_o[0]), 9);
    restart = 1'b0; tick = 1'b0;
    cyc();
    restart = 1'b1;

    // Start with S=0 is ignored.
    S = 5'd0; start = 1'b1;
    cycles(2);
    chk("s0_state", 32'(st_o[0]), 0);
    start = 1'b0;

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(63) == 0);
      restart = ($urandom_range(15) != 0);
      start   = ($urandom_range(9) == 0);
      pause   = ($urandom_range(5) != 0);
      tick    = ($urandom_range(2) == 0);
      case ($urandom_range(3))
        0: S = 5'd0;
        1: S = 5'd6;
        2: S = 5'd24;
        default: S = 5'($urandom_range(31));
      endcase
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
